// File: rtl/write_back.sv
// Writeback stage and register file of the multi-phase SIMPLE core.
// Reads operands in phase 1, latches flags in phase 3, and commits one register write in phase 4.
module write_back #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            phase_counter,
  input  logic [15:0]           instruction_register,
  input  logic [DATA_WIDTH-1:0] data_register,
  input  logic [DATA_WIDTH-1:0] memory_data,
  input  logic [3:0]            cond_in,
  input  logic                  op_reg_write,
  input  logic                  op_wb_src,
  input  logic                  op_wb_dst,
  input  logic                  op_cond_update,
  output logic [DATA_WIDTH-1:0] ar,
  output logic [DATA_WIDTH-1:0] br,
  output logic [3:0]            flags,
  output logic                  wb_done
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]     r_file [NREGS];
  logic [REG_ADDR_WIDTH-1:0] w_ra;
  logic [REG_ADDR_WIDTH-1:0] w_rb;
  logic [REG_ADDR_WIDTH-1:0] w_dst;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic                      w_read;
  logic                      w_flag_upd;
  logic                      w_commit;
  logic                      w_unused_ir;

  assign w_ra       = instruction_register[11 +: REG_ADDR_WIDTH];
  assign w_rb       = instruction_register[8 +: REG_ADDR_WIDTH];
  assign w_dst      = op_wb_dst ? w_ra : w_rb;
  assign w_wdata    = op_wb_src ? memory_data : data_register;
  assign w_read     = (phase_counter == 3'd1);
  assign w_flag_upd = (phase_counter == 3'd3) && op_cond_update;
  assign w_commit   = (phase_counter == 3'd4) && op_reg_write;
  // Only the two register fields of the instruction matter to this stage.
  assign w_unused_ir = ^{instruction_register[15:14], instruction_register[7:0]};

  // Reads and the write never share an edge, so no bypass path is needed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_file[i] <= '0;
      ar      <= '0;
      br      <= '0;
      flags   <= '0;
      wb_done <= 1'b0;
    end else begin
      wb_done <= w_commit;
      if (w_read) begin
        ar <= r_file[w_ra];
        br <= r_file[w_rb];
      end
      if (w_flag_upd) flags <= cond_in;
      if (w_commit) r_file[w_dst] <= w_wdata;
    end
  end

endmodule
